// File: rtl/mips_multicycle_core.sv
`timescale 1ns/1ps
// Multi-cycle MIPS integer-subset core with one shared req/ack memory port.
// Ports: clk, rst (async active-low), mem_req/we/addr/wdata/rdata/ack, pc, halted, illegal, instret.
module mips_multicycle_core #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ack,
   output logic [XLEN-1:0] pc,
   output logic            halted,
   output logic            illegal,
   output logic [31:0]     instret
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_HALT = 6'h3F;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_SLT = 6'h2A;

   state_t          state;
   logic [31:0]     ir;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [XLEN-1:0] alu_out;
   logic [XLEN-1:0] mdr;
   logic [XLEN-1:0] regs [32];

   logic [5:0]      op;
   logic [4:0]      rs;
   logic [4:0]      rt;
   logic [4:0]      rd;
   logic [5:0]      funct;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] jtarget;
   logic            r_ok;
   logic            legal;
   logic            take;
   logic [XLEN-1:0] alu_res;
   logic [4:0]      wb_dst;
   logic [XLEN-1:0] wb_val;

   // shamt is not used by any supported instruction
   logic unused_shamt;
   assign unused_shamt = ^ir[10:6];

   assign op    = ir[31:26];
   assign rs    = ir[25:21];
   assign rt    = ir[20:16];
   assign rd    = ir[15:11];
   assign funct = ir[5:0];
   assign imm   = {{(XLEN-16){ir[15]}}, ir[15:0]};

   // pc already holds the address of the following instruction here
   assign jtarget = {pc[XLEN-1:28], ir[25:0], 2'b00};

   always_comb begin
      r_ok = 1'b0;
      case (funct)
         F_ADD, F_SUB, F_AND, F_OR, F_SLT: r_ok = 1'b1;
         default:                          r_ok = 1'b0;
      endcase
   end

   always_comb begin
      legal = 1'b0;
      case (op)
         OP_R:    legal = r_ok;
         OP_J, OP_BEQ, OP_BNE,
         OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   assign take = (op == OP_BEQ) ? (a == b) : (a != b);

   always_comb begin
      alu_res = a + imm;
      if (op == OP_R) begin
         case (funct)
            F_ADD:   alu_res = a + b;
            F_SUB:   alu_res = a - b;
            F_AND:   alu_res = a & b;
            F_OR:    alu_res = a | b;
            F_SLT:   alu_res = {{(XLEN-1){1'b0}},
                                $signed(a) < $signed(b)};
            default: alu_res = '0;
         endcase
      end
   end

   assign wb_dst = (op == OP_R) ? rd : rt;
   assign wb_val = (op == OP_LW) ? mdr : alu_out;

   // Memory port is a pure function of state so reset drops it at once
   assign mem_req   = (state == S_FETCH) || (state == S_MEM);
   assign mem_we    = (state == S_MEM) && (op == OP_SW);
   assign mem_addr  = (state == S_FETCH) ? pc :
                      (state == S_MEM)   ? alu_out : '0;
   assign mem_wdata = mem_we ? b : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         pc      <= RESET_PC;
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         alu_out <= '0;
         mdr     <= '0;
         instret <= '0;
         halted  <= 1'b0;
         illegal <= 1'b0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_IDLE: state <= S_FETCH;
            S_FETCH: begin
               if (mem_ack) begin
                  ir    <= mem_rdata[31:0];
                  pc    <= pc + XLEN'(4);
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               a <= (rs == 5'd0) ? '0 : regs[rs];
               b <= (rt == 5'd0) ? '0 : regs[rt];
               if (op == OP_HALT) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
               end else if (!legal) begin
                  state   <= S_HALT;
                  halted  <= 1'b1;
                  illegal <= 1'b1;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (op == OP_BEQ || op == OP_BNE) begin
                  if (take) pc <= pc + (imm << 2);
                  instret <= instret + 32'd1;
                  state   <= S_FETCH;
               end else if (op == OP_J) begin
                  pc      <= jtarget;
                  instret <= instret + 32'd1;
                  state   <= S_FETCH;
               end else begin
                  alu_out <= alu_res;
                  state   <= (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
               end
            end
            S_MEM: begin
               if (mem_ack) begin
                  if (op == OP_SW) begin
                     instret <= instret + 32'd1;
                     state   <= S_FETCH;
                  end else begin
                     mdr   <= mem_rdata;
                     state <= S_WB;
                  end
               end
            end
            S_WB: begin
               if (wb_dst != 5'd0) regs[wb_dst] <= wb_val;
               instret <= instret + 32'd1;
               state   <= S_FETCH;
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_multicycle_core.sv
`timescale 1ns/1ps
// Bench for mips_multicycle_core: 32-bit and 64-bit instances behind one
// scoreboarded memory responder; only the selected instance is out of reset.
module tb_mips_multicycle_core;

   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      int          waits;
   } tx_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst32 = 1'b0;
   logic rst64 = 1'b0;
   logic sel64 = 1'b0;
   logic ack   = 1'b0;
   logic [63:0] rdata = 64'h0;

   logic        req32, we32, halted32, ill32;
   logic [31:0] addr32, wd32, pc32, iret32;
   logic        req64, we64, halted64, ill64;
   logic [63:0] addr64, wd64, pc64;
   logic [31:0] iret64;
   logic        ack32, ack64;

   assign ack32 = ack & ~sel64;
   assign ack64 = ack & sel64;

   mips_multicycle_core #(.XLEN(32), .RESET_PC(32'h100)) dut32 (
      .clk(clk), .rst(rst32),
      .mem_req(req32), .mem_we(we32), .mem_addr(addr32),
      .mem_wdata(wd32), .mem_rdata(rdata[31:0]), .mem_ack(ack32),
      .pc(pc32), .halted(halted32), .illegal(ill32), .instret(iret32)
   );

   mips_multicycle_core #(.XLEN(64), .RESET_PC(64'h0)) dut64 (
      .clk(clk), .rst(rst64),
      .mem_req(req64), .mem_we(we64), .mem_addr(addr64),
      .mem_wdata(wd64), .mem_rdata(rdata), .mem_ack(ack64),
      .pc(pc64), .halted(halted64), .illegal(ill64), .instret(iret64)
   );

   logic        req_m, we_m, halt_m, ill_m;
   logic [63:0] addr_m, wd_m, pc_m;
   logic [31:0] iret_m;
   assign req_m  = sel64 ? req64 : req32;
   assign we_m   = sel64 ? we64 : we32;
   assign halt_m = sel64 ? halted64 : halted32;
   assign ill_m  = sel64 ? ill64 : ill32;
   assign addr_m = sel64 ? addr64 : {32'h0, addr32};
   assign wd_m   = sel64 ? wd64 : {32'h0, wd32};
   assign pc_m   = sel64 ? pc64 : {32'h0, pc32};
   assign iret_m = sel64 ? iret64 : iret32;

   int total = 0;
   int bad   = 0;

   logic [63:0] mem [logic [63:0]];
   tx_t         sb [$];
   logic [63:0] pcw;
   int          fw;
   int          dw;

   // responder state
   logic        busy = 1'b0;
   int          cnt;
   tx_t         cur;
   logic [63:0] l_addr, l_wd;
   logic        l_we;

   always @(negedge clk) begin
      if (ack) begin
         ack  = 1'b0;
         busy = 1'b0;
      end
      if (req_m) begin
         if (!busy) begin
            busy   = 1'b1;
            cnt    = 0;
            l_addr = addr_m;
            l_we   = we_m;
            l_wd   = wd_m;
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_tx got addr=%h we=%b", addr_m, we_m);
               cur = '{we: we_m, addr: addr_m, wdata: wd_m, waits: 0};
            end else begin
               cur = sb[0];
               if (addr_m !== cur.addr || we_m !== cur.we ||
                   (cur.we && wd_m !== cur.wdata)) begin
                  bad++;
                  $display("FAIL tx got addr=%h we=%b wd=%h exp addr=%h we=%b wd=%h",
                           addr_m, we_m, wd_m, cur.addr, cur.we, cur.wdata);
               end
            end
         end else begin
            total++;
            if (addr_m !== l_addr || we_m !== l_we || wd_m !== l_wd) begin
               bad++;
               $display("FAIL stable got addr=%h we=%b wd=%h exp addr=%h we=%b wd=%h",
                        addr_m, we_m, wd_m, l_addr, l_we, l_wd);
            end
         end
         if (cnt == cur.waits) begin
            ack = 1'b1;
            if (we_m) mem[addr_m] = wd_m;
            else rdata = mem.exists(addr_m) ? mem[addr_m] : 64'h0;
            if (sb.size() > 0) void'(sb.pop_front());
         end else begin
            cnt++;
         end
      end
   end

   localparam logic [31:0] HALTW = 32'hFC00_0000;
   localparam logic [31:0] ILLW  = 32'h4400_0000;

   function automatic logic [31:0] ri(input logic [5:0] op,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] rr(input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic [4:0] rd,
                                      input logic [5:0] f);
      return {6'h0, rs, rt, rd, 5'h0, f};
   endfunction

   task automatic prep(input logic [63:0] base, input int f, input int d);
      sb.delete();
      mem.delete();
      pcw = base;
      fw  = f;
      dw  = d;
   endtask

   task automatic emit(input logic [31:0] w);
      mem[pcw] = {32'h0, w};
      sb.push_back('{we: 1'b0, addr: pcw, wdata: 64'h0, waits: fw});
      pcw = pcw + 64'd4;
   endtask

   task automatic place(input logic [63:0] a, input logic [31:0] w);
      mem[a] = {32'h0, w};
   endtask

   task automatic exp_d(input logic we, input logic [63:0] a,
                        input logic [63:0] d);
      sb.push_back('{we: we, addr: a, wdata: d, waits: dw});
   endtask

   task automatic start(input logic s64);
      rst32 = 1'b0;
      rst64 = 1'b0;
      ack   = 1'b0;
      busy  = 1'b0;
      sel64 = s64;
      repeat (3) @(posedge clk);
      #1;
      if (s64) rst64 = 1'b1;
      else rst32 = 1'b1;
   endtask

   task automatic wait_halt(output int n);
      n = 0;
      while (n < 2000) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (halt_m) break;
      end
   endtask

   task automatic test_reset;
      int n;
      prep(64'h100, 0, 0);
      emit(HALTW);
      sel64 = 1'b0;
      rst32 = 1'b0;
      rst64 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({req_m, we_m, halt_m, ill_m} !== 4'b0) begin
         bad++;
         $display("FAIL reset_ctl got %b exp 0000", {req_m, we_m, halt_m, ill_m});
      end
      total++;
      if (pc_m !== 64'h100 || iret_m !== 32'h0 ||
          addr_m !== 64'h0 || wd_m !== 64'h0) begin
         bad++;
         $display("FAIL reset_regs got pc=%h ir=%h a=%h wd=%h exp pc=100 rest 0",
                  pc_m, iret_m, addr_m, wd_m);
      end
      @(posedge clk);
      #1 rst32 = 1'b1;
      @(negedge clk);
      total++;
      if (req_m !== 1'b0) begin
         bad++;
         $display("FAIL idle_req got %b exp 0", req_m);
      end
      @(negedge clk);
      total++;
      if (req_m !== 1'b1 || addr_m !== 64'h100 || iret_m !== 32'h0) begin
         bad++;
         $display("FAIL first_fetch got req=%b addr=%h ir=%h exp 1 100 0",
                  req_m, addr_m, iret_m);
      end
      wait_halt(n);
      total++;
      if (n !== 2 || ill_m !== 1'b0 || iret_m !== 32'h0) begin
         bad++;
         $display("FAIL reset_halt got n=%0d ill=%b ir=%0d exp 2 0 0",
                  n, ill_m, iret_m);
      end
   endtask

   task automatic test_alu;
      int n;
      prep(64'h100, 0, 0);
      emit(ri(6'h08, 5'd0, 5'd1, 16'hFFFD));
      emit(ri(6'h08, 5'd0, 5'd2, 16'd5));
      emit(rr(5'd1, 5'd2, 5'd3, 6'h20));
      emit(rr(5'd1, 5'd2, 5'd4, 6'h2A));
      emit(rr(5'd1, 5'd2, 5'd5, 6'h22));
      emit(rr(5'd1, 5'd2, 5'd7, 6'h24));
      emit(rr(5'd1, 5'd2, 5'd8, 6'h25));
      emit(ri(6'h08, 5'd0, 5'd0, 16'd9));
      emit(ri(6'h2B, 5'd0, 5'd3, 16'h200)); exp_d(1'b1, 64'h200, 64'h2);
      emit(ri(6'h2B, 5'd0, 5'd4, 16'h204)); exp_d(1'b1, 64'h204, 64'h1);
      emit(ri(6'h2B, 5'd0, 5'd5, 16'h208)); exp_d(1'b1, 64'h208, 64'hFFFF_FFF8);
      emit(ri(6'h2B, 5'd0, 5'd7, 16'h20C)); exp_d(1'b1, 64'h20C, 64'h5);
      emit(ri(6'h2B, 5'd0, 5'd8, 16'h210)); exp_d(1'b1, 64'h210, 64'hFFFF_FFFD);
      emit(ri(6'h2B, 5'd0, 5'd0, 16'h214)); exp_d(1'b1, 64'h214, 64'h0);
      emit(HALTW);
      start(1'b0);
      wait_halt(n);
      total++;
      if (n !== 59) begin
         bad++;
         $display("FAIL alu_cycles got %0d exp 59", n);
      end
      total++;
      if (iret_m !== 32'd14 || pc_m !== 64'h13C || ill_m !== 1'b0) begin
         bad++;
         $display("FAIL alu_state got ir=%0d pc=%h ill=%b exp 14 13c 0",
                  iret_m, pc_m, ill_m);
      end
      total++;
      if (sb.size() !== 0) begin
         bad++;
         $display("FAIL alu_drain got %0d exp 0", sb.size());
      end
   endtask

   task automatic test_mem_waits;
      int n;
      prep(64'h100, 0, 2);
      emit(ri(6'h08, 5'd0, 5'd2, 16'd5));
      emit(ri(6'h2B, 5'd0, 5'd2, 16'd8));  exp_d(1'b1, 64'h8, 64'h5);
      emit(ri(6'h23, 5'd0, 5'd6, 16'd8));  exp_d(1'b0, 64'h8, 64'h0);
      emit(ri(6'h2B, 5'd0, 5'd6, 16'h10)); exp_d(1'b1, 64'h10, 64'h5);
      emit(HALTW);
      start(1'b0);
      wait_halt(n);
      total++;
      if (n !== 26) begin
         bad++;
         $display("FAIL mem_cycles got %0d exp 26", n);
      end
      total++;
      if (iret_m !== 32'd4 || pc_m !== 64'h114 || sb.size() !== 0) begin
         bad++;
         $display("FAIL mem_state got ir=%0d pc=%h q=%0d exp 4 114 0",
                  iret_m, pc_m, sb.size());
      end
   endtask

   task automatic test_branch;
      int n;
      prep(64'h100, 0, 0);
      emit(ri(6'h08, 5'd0, 5'd1, 16'd1));
      emit(ri(6'h08, 5'd0, 5'd2, 16'd2));
      emit(ri(6'h05, 5'd1, 5'd2, 16'd2));
      place(64'h10C, ILLW);
      place(64'h110, ILLW);
      pcw = 64'h114;
      emit(ri(6'h04, 5'd1, 5'd2, 16'd5));
      place(64'h12C, ILLW);
      emit({6'h02, 26'h50});
      place(64'h11C, ILLW);
      pcw = 64'h140;
      emit(HALTW);
      start(1'b0);
      wait_halt(n);
      total++;
      if (n !== 20) begin
         bad++;
         $display("FAIL br_cycles got %0d exp 20", n);
      end
      total++;
      if (iret_m !== 32'd5 || pc_m !== 64'h144 ||
          ill_m !== 1'b0 || sb.size() !== 0) begin
         bad++;
         $display("FAIL br_state got ir=%0d pc=%h ill=%b q=%0d exp 5 144 0 0",
                  iret_m, pc_m, ill_m, sb.size());
      end
   endtask

   task automatic test_xlen64;
      int n;
      prep(64'h0, 0, 0);
      mem[64'h90] = 64'h1234_5678_9ABC_DEF0;
      emit(ri(6'h08, 5'd0, 5'd1, 16'hFFFF));
      emit(rr(5'd1, 5'd1, 5'd2, 6'h20));
      emit(ri(6'h2B, 5'd0, 5'd2, 16'h80)); exp_d(1'b1, 64'h80, 64'hFFFF_FFFF_FFFF_FFFE);
      emit(ri(6'h23, 5'd0, 5'd3, 16'h80)); exp_d(1'b0, 64'h80, 64'h0);
      emit(ri(6'h2B, 5'd0, 5'd3, 16'h88)); exp_d(1'b1, 64'h88, 64'hFFFF_FFFF_FFFF_FFFE);
      emit(ri(6'h23, 5'd0, 5'd4, 16'h90)); exp_d(1'b0, 64'h90, 64'h0);
      emit(ri(6'h2B, 5'd0, 5'd4, 16'h98)); exp_d(1'b1, 64'h98, 64'h1234_5678_9ABC_DEF0);
      emit(HALTW);
      start(1'b1);
      wait_halt(n);
      total++;
      if (n !== 33) begin
         bad++;
         $display("FAIL x64_cycles got %0d exp 33", n);
      end
      total++;
      if (iret_m !== 32'd7 || pc_m !== 64'h20 || sb.size() !== 0) begin
         bad++;
         $display("FAIL x64_state got ir=%0d pc=%h q=%0d exp 7 20 0",
                  iret_m, pc_m, sb.size());
      end
   endtask

   task automatic test_illegal;
      int n;
      prep(64'h100, 0, 0);
      emit(ri(6'h08, 5'd0, 5'd1, 16'd7));
      emit(ILLW);
      start(1'b0);
      wait_halt(n);
      total++;
      if (n !== 7 || ill_m !== 1'b1 || iret_m !== 32'd1 || pc_m !== 64'h108) begin
         bad++;
         $display("FAIL ill_halt got n=%0d ill=%b ir=%0d pc=%h exp 7 1 1 108",
                  n, ill_m, iret_m, pc_m);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (req_m !== 1'b0 || halt_m !== 1'b1 || iret_m !== 32'd1) begin
            bad++;
            $display("FAIL halt_frozen got req=%b h=%b ir=%0d exp 0 1 1",
                     req_m, halt_m, iret_m);
         end
      end
      prep(64'h100, 0, 0);
      emit(ri(6'h08, 5'd0, 5'd1, 16'd7));
      emit(ILLW);
      rst32 = 1'b0;
      #1;
      total++;
      if (halt_m !== 1'b0 || ill_m !== 1'b0 || req_m !== 1'b0 ||
          pc_m !== 64'h100 || iret_m !== 32'h0) begin
         bad++;
         $display("FAIL rst_pulse got h=%b ill=%b req=%b pc=%h ir=%0d exp 0 0 0 100 0",
                  halt_m, ill_m, req_m, pc_m, iret_m);
      end
      @(posedge clk);
      #1 rst32 = 1'b1;
      wait_halt(n);
      total++;
      if (n !== 7 || ill_m !== 1'b1 || iret_m !== 32'd1 || sb.size() !== 0) begin
         bad++;
         $display("FAIL rerun got n=%0d ill=%b ir=%0d q=%0d exp 7 1 1 0",
                  n, ill_m, iret_m, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mem_waits();
      test_branch();
      test_xlen64();
      test_illegal();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
